// File: rtl/frog_controller.sv
// Three-frog hop controller: edge-triggered hops, slot homing, death hold.
// All outputs registered; reset release is synchronised to frame_clk.
module frog_controller #(
  parameter int HOP          = 40,
  parameter int START_X      = 320,
  parameter int START_Y      = 440,
  parameter int HOME_Y       = 40,
  parameter int SLOT0        = 120,
  parameter int SLOT1        = 280,
  parameter int SLOT2        = 480,
  parameter int MAX_X        = 600,
  parameter int DEATH_FRAMES = 30
) (
  input  logic        frame_clk,
  input  logic        game_restart_n,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        hazard,
  input  logic        freeze,
  output logic [10:0] Frog1_X,
  output logic [10:0] Frog1_Y,
  output logic [10:0] Frog2_X,
  output logic [10:0] Frog2_Y,
  output logic [10:0] Frog3_X,
  output logic [10:0] Frog3_Y,
  output logic        dead_frog,
  output logic [1:0]  active_frog
);

  localparam int CW = $clog2(DEATH_FRAMES + 1);
  localparam logic [10:0] L_HOP = 11'(HOP);
  localparam logic [10:0] L_SX  = 11'(START_X);
  localparam logic [10:0] L_SY  = 11'(START_Y);
  localparam logic [10:0] L_HY  = 11'(HOME_Y);
  localparam logic [10:0] L_S0  = 11'(SLOT0);
  localparam logic [10:0] L_S1  = 11'(SLOT1);
  localparam logic [10:0] L_S2  = 11'(SLOT2);
  localparam logic [10:0] L_MX  = 11'(MAX_X);
  localparam logic [CW-1:0] L_DL = CW'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {PLAY, DYING, HOMED, DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [3:0]    r_kprev;
  logic [2:0]    r_occ;
  logic [CW-1:0] r_cnt;
  logic [10:0]   r_x [3];
  logic [10:0]   r_y [3];

  logic        w_run;
  logic [3:0]  w_keys;
  logic [3:0]  w_edge;
  logic [10:0] w_cx;
  logic [10:0] w_cy;
  logic [10:0] w_nx;
  logic [10:0] w_ny;
  logic        w_hop;
  logic [2:0]  w_hit;
  logic        w_free;
  logic [1:0]  w_next;

  assign w_run  = r_sync[1];
  assign w_keys = {key_up, key_down, key_left, key_right};
  assign w_edge = w_keys & ~r_kprev;
  assign w_next = active_frog + 2'd1;
  assign w_hit  = {w_cx == L_S2, w_cx == L_S1, w_cx == L_S0};
  assign w_free = |(w_hit & ~r_occ);

  assign Frog1_X = r_x[0];
  assign Frog1_Y = r_y[0];
  assign Frog2_X = r_x[1];
  assign Frog2_Y = r_y[1];
  assign Frog3_X = r_x[2];
  assign Frog3_Y = r_y[2];

  always_comb begin
    w_cx = r_x[0];
    w_cy = r_y[0];
    if (active_frog == 2'd1) begin
      w_cx = r_x[1];
      w_cy = r_y[1];
    end else if (active_frog == 2'd2) begin
      w_cx = r_x[2];
      w_cy = r_y[2];
    end
  end

  // Only the highest-priority edge is considered; if illegal, no hop at all.
  always_comb begin
    w_hop = 1'b0;
    w_nx  = w_cx;
    w_ny  = w_cy;
    if (w_edge[3]) begin
      w_ny  = w_cy - L_HOP;
      w_hop = (w_cy >= L_HY + L_HOP) &&
              ((w_ny != L_HY) || w_free);
    end else if (w_edge[2]) begin
      w_ny  = w_cy + L_HOP;
      w_hop = (w_cy <= L_SY - L_HOP);
    end else if (w_edge[1]) begin
      w_nx  = w_cx - L_HOP;
      w_hop = (w_cx >= L_HOP);
    end else if (w_edge[0]) begin
      w_nx  = w_cx + L_HOP;
      w_hop = (w_cx <= L_MX - L_HOP);
    end
  end

  always_ff @(posedge frame_clk or negedge game_restart_n) begin
    if (!game_restart_n) r_sync <= 2'b00;
    else                 r_sync <= {r_sync[0], 1'b1};
  end

  always_ff @(posedge frame_clk or negedge game_restart_n) begin
    if (!game_restart_n) begin
      r_state     <= PLAY;
      active_frog <= 2'd0;
      dead_frog   <= 1'b0;
      r_kprev     <= 4'hF;
      r_occ       <= 3'b000;
      r_cnt       <= '0;
      r_x[0]      <= L_SX;
      r_y[0]      <= L_SY;
      r_x[1]      <= '0;
      r_y[1]      <= '0;
      r_x[2]      <= '0;
      r_y[2]      <= '0;
    end else begin
      r_kprev   <= w_keys;
      dead_frog <= 1'b0;
      if (w_run && !freeze) begin
        unique case (r_state)
          PLAY: begin
            if (hazard && w_cy != L_HY) begin
              r_state   <= DYING;
              dead_frog <= 1'b1;
              r_cnt     <= '0;
            end else if (w_hop) begin
              for (int i = 0; i < 3; i++) begin
                if (active_frog == 2'(i)) begin
                  r_x[i] <= w_nx;
                  r_y[i] <= w_ny;
                end
              end
              if (w_ny == L_HY) begin
                r_state <= HOMED;
                r_occ   <= r_occ | w_hit;
              end
            end
          end
          DYING: begin
            if (r_cnt == L_DL) begin
              r_state <= PLAY;
              for (int i = 0; i < 3; i++) begin
                if (active_frog == 2'(i)) begin
                  r_x[i] <= L_SX;
                  r_y[i] <= L_SY;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          HOMED: begin
            active_frog <= w_next;
            if (w_next == 2'd3) begin
              r_state <= DONE;
            end else begin
              r_state <= PLAY;
              for (int i = 0; i < 3; i++) begin
                if (w_next == 2'(i)) begin
                  r_x[i] <= L_SX;
                  r_y[i] <= L_SY;
                end
              end
            end
          end
          DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frog_controller.sv
// Directed bench for frog_controller: hops, boundaries, homing,
// death hold, freeze and reset behaviour.
module tb_frog_controller;

  logic        clk;
  logic        rst_n;
  logic        ku, kd, kl, kr;
  logic        hazard, freeze;
  logic [10:0] f1x, f1y, f2x, f2y, f3x, f3y;
  logic        dead;
  logic [1:0]  af;

  int n_vec = 0;
  int n_err = 0;
  int n_dead = 0;

  frog_controller dut (
    .frame_clk      (clk),
    .game_restart_n (rst_n),
    .key_up         (ku),
    .key_down       (kd),
    .key_left       (kl),
    .key_right      (kr),
    .hazard         (hazard),
    .freeze         (freeze),
    .Frog1_X        (f1x),
    .Frog1_Y        (f1y),
    .Frog2_X        (f2x),
    .Frog2_Y        (f2y),
    .Frog3_X        (f3x),
    .Frog3_Y        (f3y),
    .dead_frog      (dead),
    .active_frog    (af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dead === 1'b1) n_dead++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      case (k)
        0: ku = 1'b1;
        1: kd = 1'b1;
        2: kl = 1'b1;
        default: kr = 1'b1;
      endcase
      step(1);
      ku = 1'b0; kd = 1'b0; kl = 1'b0; kr = 1'b0;
      step(1);
    end
  endtask

  initial begin
    ku = 0; kd = 0; kl = 0; kr = 0;
    hazard = 0; freeze = 0; rst_n = 1'b0;
    step(2);
    chk("rst_f1x", f1x, 320);
    chk("rst_f1y", f1y, 440);
    chk("rst_f2x", f2x, 0);
    chk("rst_f2y", f2y, 0);
    chk("rst_f3x", f3x, 0);
    chk("rst_f3y", f3y, 0);
    chk("rst_af", af, 0);
    chk("rst_dead", dead, 0);

    ku = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(4);
    chk("held_key_rst", f1y, 440);
    ku = 1'b0;
    step(1);

    ku = 1'b1;
    step(1);
    chk("up1", f1y, 400);
    step(5);
    chk("up_hold", f1y, 400);
    ku = 1'b0;
    step(1);

    press(1, 1);
    chk("down", f1y, 440);
    press(1, 1);
    chk("down_bound", f1y, 440);

    ku = 1'b1; kr = 1'b1;
    step(1);
    chk("prio_x", f1x, 320);
    chk("prio_y", f1y, 400);
    ku = 1'b0; kr = 1'b0;
    step(1);

    press(2, 8);
    chk("left_to0", f1x, 0);
    press(2, 1);
    chk("left_bound", f1x, 0);
    press(3, 15);
    chk("right_to600", f1x, 600);
    press(3, 1);
    chk("right_bound", f1x, 600);
    press(2, 12);
    chk("left_to120", f1x, 120);

    hazard = 1'b1; kr = 1'b1;
    step(1);
    chk("die_pulse", dead, 1);
    chk("die_nohop", f1x, 120);
    kr = 1'b0;
    step(1);
    chk("die_pulse_end", dead, 0);
    step(1);
    chk("die_no2nd", dead, 0);
    hazard = 1'b0;
    step(27);
    chk("die_hold_x", f1x, 120);
    chk("die_hold_y", f1y, 400);
    chk("die_count", n_dead, 1);
    step(1);
    chk("respawn_x", f1x, 320);
    chk("respawn_y", f1y, 440);
    chk("respawn_af", af, 0);

    press(2, 5);
    press(0, 9);
    chk("f1_at80", f1y, 80);
    ku = 1'b1;
    step(1);
    chk("f1_home_x", f1x, 120);
    chk("f1_home_y", f1y, 40);
    ku = 1'b0;
    step(1);
    chk("f1_af1", af, 1);
    chk("f2_spawn_x", f2x, 320);
    chk("f2_spawn_y", f2y, 440);

    press(2, 3);
    press(0, 9);
    press(0, 1);
    chk("noslot_up", f2y, 80);
    press(3, 2);
    press(0, 1);
    chk("f2_home_x", f2x, 280);
    chk("f2_home_y", f2y, 40);
    chk("f2_af2", af, 2);
    chk("f3_spawn_y", f3y, 440);

    press(2, 5);
    press(0, 9);
    press(0, 1);
    chk("occ120_up", f3y, 80);
    press(3, 4);
    press(0, 1);
    chk("occ280_up", f3y, 80);
    press(3, 5);
    press(0, 1);
    chk("done_af", af, 3);
    chk("done_f3x", f3x, 480);
    chk("done_f3y", f3y, 40);
    chk("done_f1x", f1x, 120);
    chk("done_f2x", f2x, 280);

    press(1, 1);
    chk("done_hold", f3y, 40);
    freeze = 1'b1; hazard = 1'b1;
    step(3);
    chk("frz_nodead", dead, 0);
    freeze = 1'b0;
    step(2);
    chk("done_nopulse", n_dead, 1);
    hazard = 1'b0;

    rst_n = 1'b0;
    step(1);
    chk("rst2_af", af, 0);
    rst_n = 1'b1;
    step(3);

    freeze = 1'b1; ku = 1'b1;
    step(2);
    chk("frz_nohop", f1y, 440);
    freeze = 1'b0;
    step(2);
    chk("frz_release", f1y, 440);
    ku = 1'b0;
    step(1);

    press(0, 1);
    chk("pre_die_y", f1y, 400);
    hazard = 1'b1;
    step(1);
    chk("die2_pulse", dead, 1);
    hazard = 1'b0;
    step(5);
    chk("die2_hold", f1y, 400);
    rst_n = 1'b0;
    #1;
    chk("middie_rst_y", f1y, 440);
    chk("middie_rst_x", f1x, 320);
    chk("middie_rst_af", af, 0);
    chk("middie_rst_dead", dead, 0);
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frog_controller.md
FROG_CONTROLLER -- requirements
Module: frog_controller

Interface
REQ-001 Parameters (name, default, meaning): HOP 40 (pixels per hop); START_X 320, START_Y 440 (spawn point); HOME_Y 40 (home row); SLOT0/1/2 120/280/480 (home X slots); MAX_X 600; DEATH_FRAMES 30 (death hold, frames).
REQ-002 Ports (name, direction, width, meaning):
REQ-003 frame_clk  in  1  sole clock, one rising edge per video frame.
REQ-004 game_restart_n  in  1  asynchronous, active-low reset.
REQ-005 key_up, key_down, key_left, key_right  in  1 each  level-sensitive keyboard direction inputs.
REQ-006 hazard  in  1  active frog overlaps a car or open water this frame.
REQ-007 freeze  in  1  game over (win_game OR lose_game from the game-state block).
REQ-008 Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y  out  11 each  frog top-left pixel positions.
REQ-009 dead_frog  out  1  one-cycle pulse per death.
REQ-010 active_frog  out  2  index (0..2) of frog under player control; 3 = all homed.

Function
REQ-011 States: PLAY, DYING, HOMED, DONE; all outputs registered.
REQ-012 Frogs play sequentially; only frog[active_frog] moves; unspawned frogs sit at (0,0); homed frogs hold their slot coordinates permanently.
REQ-013 Hop trigger: rising edge of a key (registered previous value 0, current 1); held key gives one hop only.
REQ-014 Simultaneous edges in one cycle: exactly one hop, priority up > down > left > right.
REQ-015 Hop applies HOP to Y (up: -, down: +) or X (left: -, right: +) on the edge cycle; latency one frame_clk.
REQ-016 Hop ignored if the result leaves X in [0, MAX_X] or Y in [HOME_Y, START_Y]; no wrap-around, no underflow of the 11-bit value.
REQ-017 Up hop into HOME_Y allowed only if X equals an unoccupied slot; otherwise ignored.
REQ-018 PLAY -> HOMED when the active frog reaches Y = HOME_Y; slot marked occupied.
REQ-019 HOMED (one cycle): active_frog increments; if new index < 3, that frog spawns at (START_X, START_Y) and -> PLAY; else active_frog = 3 and -> DONE.
REQ-020 PLAY -> DYING when hazard = 1 and active frog Y != HOME_Y; dead_frog = 1 only on the first DYING cycle.
REQ-021 Hazard takes precedence over a same-cycle hop: hop discarded.
REQ-022 DYING: position held, inputs ignored, counts DEATH_FRAMES cycles, then same frog respawns at (START_X, START_Y) -> PLAY; hazard during DYING never produces a second pulse.
REQ-023 DONE: all positions held, no pulses, until reset.
REQ-024 freeze = 1 in any state: hops, hazard and death counter suspended, positions held, dead_frog = 0; resumes from same state when freeze drops.
REQ-025 Key edge detector keeps sampling during freeze/DYING so a key held across them causes no hop on release of freeze.

Reset
REQ-026 game_restart_n low (any time, mid-death included): state PLAY, active_frog 0, Frog1 = (320, 440), Frog2 = Frog3 = (0, 0), dead_frog 0, slots unoccupied, death counter 0, key history = current key levels sampled as 1 (no hop on release of reset).
REQ-027 Reset deassertion is synchronised; first state change no earlier than the second frame_clk edge after release.

Verification
REQ-028 Reset, pulse key_up 0->1 once, hold 5 frames -> Frog1_Y 440 -> 400 once, stays 400.
REQ-029 From (320,440): key_left x5, key_up x10 -> Frog1 = (120, 40), active_frog 1, Frog2 = (320, 440) next cycle.
REQ-030 hazard high 3 frames at Frog1 (320,400) -> single dead_frog pulse, Frog1 held 30 frames, then (320, 440), active_frog still 0.
REQ-031 key_up and key_right edges same cycle at (320,440) -> (320,400) only; key_left at X = 0 -> X unchanged.
REQ-032 Frog at (280,80) with slot 280 occupied, key_up -> Y stays 80; at (200,80) key_up -> ignored.
REQ-033 All three frogs homed -> active_frog 3, positions (120/280/480, 40); freeze = 1 then hazard -> no pulse; reset mid-DYING -> REQ-026 values immediately.
